// File: rtl/sipo_deser_pkg.sv
// -----------------------------------------------------------------------------
// sipo_deser_pkg
// Shared constants for the serial-in / parallel-out deserializer.
//   ST_FILL     : still collecting bits of the current word (includes cnt == 0)
//   ST_COMPLETE : the edge that samples the last bit of a word
// The control FSM is implicit (derived from the bit counter), so these encode
// the decoded state rather than a stored state register.
// -----------------------------------------------------------------------------
package sipo_deser_pkg;

    localparam logic [0:0] ST_FILL     = 1'b0;
    localparam logic [0:0] ST_COMPLETE = 1'b1;

endpackage : sipo_deser_pkg

// File: rtl/sipo_deser_shift_core.sv
// -----------------------------------------------------------------------------
// sipo_deser_shift_core
// Shift register plus bit counter. Rebuilds an LSB-first word and flags the
// cycle on which the final bit of a word is being sampled.
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   sin        in   serial data bit
//   sin_en     in   sample sin on this edge
//   clr        in   synchronous abort of the partial word (beats sin_en)
//   word_done  out  combinational: a word completes on this edge
//   word       out  combinational: the completed word {sin, sh[N-1:1]}
//   cnt        out  registered count of bits received in the current word
// -----------------------------------------------------------------------------
module sipo_deser_shift_core
    import sipo_deser_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          sin,
    input  logic          sin_en,
    input  logic          clr,
    output logic          word_done,
    output logic [N-1:0]  word,
    output logic [CW-1:0] cnt
);

    // Only the upper N-1 bits of the conceptual shift register ever reach the
    // output (bit 0 is shifted out as the new bit arrives), so just those are
    // stored: r_sh holds sh[N-1:1].
    logic [N-2:0]  r_sh;
    logic [CW-1:0] r_cnt;
    logic [0:0]    w_state;
    logic [N-1:0]  w_word;

    assign w_word = {sin, r_sh};

    // Decode the implicit FSM state from the counter and the sample enable.
    always_comb begin
        w_state = ST_FILL;
        if (!clr && sin_en && (r_cnt == CW'(N - 1))) begin
            w_state = ST_COMPLETE;
        end else begin
            w_state = ST_FILL;
        end
    end

    assign word_done = (w_state == ST_COMPLETE);
    assign word      = w_word;
    assign cnt       = r_cnt;

    // Shift register and bit counter; clr beats sin_en and discards the partial word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (clr) begin
            r_sh  <= '0;
            r_cnt <= '0;
        end else if (sin_en) begin
            // New bit enters at the MSB; the top N-1 bits of the shifted value are kept.
            r_sh  <= w_word[N-1:1];
            r_cnt <= word_done ? '0 : (r_cnt + CW'(1));
        end else begin
            r_sh  <= r_sh;
            r_cnt <= r_cnt;
        end
    end

endmodule : sipo_deser_shift_core

// File: rtl/sipo_deser.sv
// -----------------------------------------------------------------------------
// sipo_deser
// Serial-in, parallel-out deserializer with valid/ready output and sticky
// overrun detection. Bit 0 of dout is the first bit received.
// Ports:
//   clk         in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   sin         in   serial data bit
//   sin_en      in   sin is valid this cycle
//   clr         in   synchronous abort: drop partial word, clear overrun
//   dout        out  assembled word (registered)
//   dout_valid  out  dout holds an unconsumed word (registered)
//   dout_ready  in   consumer takes dout when dout_valid is high
//   bit_cnt     out  bits received of the current partial word (registered)
//   overrun     out  sticky: a completed word was dropped (registered)
// -----------------------------------------------------------------------------
module sipo_deser
    import sipo_deser_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sin,
    input  logic                 sin_en,
    input  logic                 clr,
    output logic [N-1:0]         dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic [$clog2(N)-1:0] bit_cnt,
    output logic                 overrun
);

    localparam int CW = $clog2(N);

    logic          w_word_done;
    logic [N-1:0]  w_word;
    logic [CW-1:0] w_cnt;

    logic [N-1:0]  r_dout;
    logic          r_dout_valid;
    logic          r_overrun;

    sipo_deser_shift_core #(
        .N  (N),
        .CW (CW)
    ) u_core (
        .clk       (clk),
        .reset_n   (reset_n),
        .sin       (sin),
        .sin_en    (sin_en),
        .clr       (clr),
        .word_done (w_word_done),
        .word      (w_word),
        .cnt       (w_cnt)
    );

    // Output holding register: load on completion when the slot is free or
    // being drained this cycle, otherwise retire the held word on acceptance.
    // clr does not touch this register, so a held word survives an abort.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else if (w_word_done && (!r_dout_valid || dout_ready)) begin
            r_dout       <= w_word;
            r_dout_valid <= 1'b1;
        end else if (r_dout_valid && dout_ready && !w_word_done) begin
            r_dout       <= r_dout;
            r_dout_valid <= 1'b0;
        end else begin
            r_dout       <= r_dout;
            r_dout_valid <= r_dout_valid;
        end
    end

    // Sticky overrun: set when a completed word finds the slot full and not
    // draining; only clr or reset clear it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overrun <= 1'b0;
        end else if (clr) begin
            r_overrun <= 1'b0;
        end else if (w_word_done && r_dout_valid && !dout_ready) begin
            r_overrun <= 1'b1;
        end else begin
            r_overrun <= r_overrun;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign overrun    = r_overrun;
    assign bit_cnt    = w_cnt;

endmodule : sipo_deser

// File: tb/tb_sipo_deser.sv
// -----------------------------------------------------------------------------
// tb_sipo_deser
// Self-checking bench for sipo_deser (N=4). Expected words are pushed to a
// scoreboard queue when their last bit is driven and popped when the DUT
// presents them on dout.
// -----------------------------------------------------------------------------
module tb_sipo_deser;

    localparam int N = 4;

    logic         clk;
    logic         reset_n;
    logic         sin;
    logic         sin_en;
    logic         clr;
    logic [N-1:0] dout;
    logic         dout_valid;
    logic         dout_ready;
    logic [1:0]   bit_cnt;
    logic         overrun;

    int n_checks;
    int n_errors;
    logic [N-1:0] sb_q[$];

    sipo_deser #(.N(N)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sin        (sin),
        .sin_en     (sin_en),
        .clr        (clr),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .bit_cnt    (bit_cnt),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge, then settle 1 time unit past it before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one word LSB-first on consecutive cycles; ready_last sets
    // dout_ready for the completing edge; push_exp records it in the scoreboard.
    task automatic send_word(input logic [N-1:0] w, input logic ready_last, input logic push_exp);
        for (int i = 0; i < N; i++) begin
            sin    = w[i];
            sin_en = 1'b1;
            if (i == N - 1) begin
                dout_ready = ready_last;
                if (push_exp) sb_q.push_back(w);
            end
            tick();
        end
        sin_en = 1'b0;
        sin    = 1'b0;
    endtask

    // Pop the scoreboard head and compare with dout.
    task automatic check_word(input string name);
        logic [N-1:0] exp_w;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s: scoreboard empty, dout=%h", name, dout);
        end else begin
            exp_w = sb_q.pop_front();
            if (dout !== exp_w || dout_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL %s: dout=%h valid=%b, expected dout=%h valid=1", name, dout, dout_valid, exp_w);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; sin = 1'b0; sin_en = 1'b0; clr = 1'b0; dout_ready = 1'b0;
        tick(); tick();
        n_checks++;
        if ({dout, dout_valid, bit_cnt, overrun} !== 8'h00) begin
            n_errors++;
            $display("FAIL reset: dout=%h valid=%b cnt=%0d ovr=%b, expected all 0", dout, dout_valid, bit_cnt, overrun);
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [N-1:0] w;
        logic [1:0]   exp_cnt;
        w = 4'hD;
        dout_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            sin = w[i]; sin_en = 1'b1;
            if (i == N - 1) sb_q.push_back(w);
            tick();
            exp_cnt = 2'(i + 1);
            n_checks++;
            if (bit_cnt !== exp_cnt) begin
                n_errors++;
                $display("FAIL basic_cnt: bit_cnt=%0d, expected %0d", bit_cnt, exp_cnt);
            end
            if (i < N - 1) begin
                n_checks++;
                if (dout_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL basic_early_valid: dout_valid=%b, expected 0", dout_valid);
                end
            end
        end
        sin_en = 1'b0;
        check_word("basic_word");
        tick();
        n_checks++;
        if (dout_valid !== 1'b0 || dout !== 4'hD) begin
            n_errors++;
            $display("FAIL basic_drain: valid=%b dout=%h, expected valid=0 dout=d", dout_valid, dout);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] stream;
        stream = 8'h3A;  // 0xA first, then 0x3, LSB-first
        dout_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sin = stream[i]; sin_en = 1'b1;
            if (i == 3) sb_q.push_back(4'hA);
            if (i == 7) sb_q.push_back(4'h3);
            tick();
            if (i == 3 || i == 7) begin
                check_word("b2b_word");
            end else begin
                n_checks++;
                if (dout_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL b2b_gap_valid: cycle %0d dout_valid=%b, expected 0", i, dout_valid);
                end
            end
        end
        sin_en = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_overrun: overrun=%b, expected 0", overrun);
        end
        tick();
    endtask

    task automatic test_overrun();
        send_word(4'h5, 1'b0, 1'b1);
        dout_ready = 1'b0;
        send_word(4'h9, 1'b0, 1'b0);   // dropped: slot full, not draining
        check_word("ovr_held");
        n_checks++;
        if (overrun !== 1'b1) begin
            n_errors++;
            $display("FAIL ovr_set: overrun=%b, expected 1", overrun);
        end
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        n_checks++;
        if (dout_valid !== 1'b0 || overrun !== 1'b1 || dout !== 4'h5) begin
            n_errors++;
            $display("FAIL ovr_drain: valid=%b ovr=%b dout=%h, expected valid=0 ovr=1 dout=5", dout_valid, overrun, dout);
        end
    endtask

    task automatic test_same_cycle();
        clr = 1'b1; tick(); clr = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL same_clr: overrun=%b, expected 0", overrun);
        end
        send_word(4'h5, 1'b0, 1'b0);
        n_checks++;
        if (dout !== 4'h5 || dout_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL same_hold: dout=%h valid=%b, expected 5/1", dout, dout_valid);
        end
        dout_ready = 1'b0;
        send_word(4'hC, 1'b1, 1'b1);    // ready only on the completing edge
        dout_ready = 1'b0;
        check_word("same_replace");
        n_checks++;
        if (overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL same_overrun: overrun=%b, expected 0", overrun);
        end
        dout_ready = 1'b1; tick();
    endtask

    task automatic test_gap_clr();
        dout_ready = 1'b0;
        send_word(4'h1, 1'b0, 1'b0);
        send_word(4'h2, 1'b0, 1'b0);    // sets overrun
        dout_ready = 1'b1; tick(); dout_ready = 1'b0;
        n_checks++;
        if (overrun !== 1'b1) begin
            n_errors++;
            $display("FAIL gap_pre_ovr: overrun=%b, expected 1", overrun);
        end
        sin_en = 1'b1; sin = 1'b1; tick();
        sin = 1'b1; tick();
        sin_en = 1'b0; sin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sin = ~sin;                 // toggling sin during a gap must be ignored
            tick();
            n_checks++;
            if (bit_cnt !== 2'd2) begin
                n_errors++;
                $display("FAIL gap_cnt: bit_cnt=%0d, expected 2", bit_cnt);
            end
        end
        clr = 1'b1; sin_en = 1'b1; sin = 1'b1;  // clr beats sin_en
        tick();
        clr = 1'b0; sin_en = 1'b0;
        n_checks++;
        if (bit_cnt !== 2'd0 || overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL gap_clr: bit_cnt=%0d ovr=%b, expected 0/0", bit_cnt, overrun);
        end
        send_word(4'h6, 1'b1, 1'b1);
        check_word("gap_word");
        dout_ready = 1'b1; tick();
    endtask

    task automatic test_async_reset();
        dout_ready = 1'b0;
        send_word(4'hA, 1'b0, 1'b0);    // held word that reset must discard
        for (int i = 0; i < 3; i++) begin
            sin = 1'b1; sin_en = 1'b1; tick();
        end
        sin_en = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({dout, dout_valid, bit_cnt, overrun} !== 8'h00) begin
            n_errors++;
            $display("FAIL async_reset: dout=%h valid=%b cnt=%0d ovr=%b, expected all 0", dout, dout_valid, bit_cnt, overrun);
        end
        tick();
        reset_n = 1'b1;
        tick();
        sb_q.delete();
        send_word(4'hF, 1'b1, 1'b1);
        check_word("post_reset_word");
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_overrun();
        test_same_cycle();
        test_gap_clr();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sipo_deser
